// File: rtl/string_serializer.sv
// Parallel-to-serial front end feeding the 0110 detector: valid/ready word load, one bit per clock,
// idle fill between words. Define SER_LSB_FIRST_EN to send load_data[0] first (default: MSB first).
module string_serializer #(
  parameter int   DATA_W   = 16,
  parameter int   LEN_W    = 6,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_done,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] sr, sr_nx;
  logic [LEN_W-1:0]  rem, rem_nx;
  logic              ser_out_nx, ser_valid_nx, word_done_nx, busy_nx;

  logic              accept;
  logic [LEN_W-1:0]  len_eff;
  logic              first_bit, next_bit;
  logic [DATA_W-1:0] load_sr, shifted_sr;

  assign load_ready = (state == S_IDLE) || (rem == LEN_W'(1));
  assign accept     = load_valid && load_ready;
  assign len_eff    = (load_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : load_len;

  // ser_out already holds the current bit; sr holds only the bits still to come.
  always_comb begin
`ifdef SER_LSB_FIRST_EN
    first_bit  = load_data[0];
    load_sr    = load_data >> 1;
    next_bit   = sr[0];
    shifted_sr = sr >> 1;
`else
    // Left-align the word so bit L-1 sits at the MSB and shifts out first.
    load_sr    = load_data << (LEN_W'(DATA_W) - len_eff);
    first_bit  = load_sr[DATA_W-1];
    load_sr    = load_sr << 1;
    next_bit   = sr[DATA_W-1];
    shifted_sr = sr << 1;
`endif
  end

  // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    rem_nx       = rem;
    ser_out_nx   = ser_out;
    ser_valid_nx = ser_valid;
    word_done_nx = 1'b0;
    busy_nx      = busy;

    case (state)
      S_SHIFT: begin
        if (rem > LEN_W'(1)) begin
          ser_out_nx   = next_bit;
          sr_nx        = shifted_sr;
          rem_nx       = rem - LEN_W'(1);
          word_done_nx = (rem == LEN_W'(2));
        end else begin
          state_nx     = S_IDLE;
          sr_nx        = '0;
          rem_nx       = '0;
          ser_out_nx   = IDLE_BIT;
          ser_valid_nx = 1'b0;
          busy_nx      = 1'b0;
        end
      end
      default: ;
    endcase

    // A zero-length word is consumed by the handshake but never loaded.
    if (accept && (len_eff != '0)) begin
      state_nx     = S_SHIFT;
      sr_nx        = load_sr;
      rem_nx       = len_eff;
      ser_out_nx   = first_bit;
      ser_valid_nx = 1'b1;
      word_done_nx = (len_eff == LEN_W'(1));
      busy_nx      = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      sr        <= '0;
      rem       <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      rem       <= rem_nx;
      ser_out   <= ser_out_nx;
      ser_valid <= ser_valid_nx;
      word_done <= word_done_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: doc/string_serializer.md
# string_serializer

Parallel-to-serial front end for the string-recognition path. Accepts a parallel word and a bit length through a valid/ready handshake, then drives one bit per clock onto `ser_out`, which connects directly to the `seq_in` input of the 0110 Moore detector. Between words, `ser_out` holds a configurable idle level so the detector is not fed spurious pattern starts. Back-to-back words stream with no gap bits.

## Interface
- `DATA_W`, 16, width of `load_data` and the maximum bits per word (2..32).
- `LEN_W`, 6, width of `load_len`; must satisfy 2^LEN_W > DATA_W.
- `IDLE_BIT`, 1'b1, level driven on `ser_out` when no word is shifting (1 keeps the detector in its reset state).

- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_valid`  in  1  upstream has a word on `load_data`/`load_len`.
- `load_ready`  out  1  block will accept a word this cycle.
- `load_data`  in  DATA_W  bits to send; only the low `load_len` bits are used.
- `load_len`  in  LEN_W  number of bits to send.
- `ser_out`  out  1  serial bit to the detector's `seq_in`.
- `ser_valid`  out  1  `ser_out` carries a word bit, not idle fill.
- `word_done`  out  1  single-cycle pulse during the cycle the last bit of a word is on `ser_out`.
- `busy`  out  1  a word is currently shifting.

## Operation
- Two states:
  - IDLE: `ser_out`=IDLE_BIT, `ser_valid`=0, `busy`=0.
  - SHIFT: a shift register plus a remaining-bit counter `rem`.
- `load_ready` is combinational and high when:
  - in IDLE, or
  - in SHIFT with `rem`==1 (last bit presented).
- Accept occurs when `load_valid && load_ready` at a rising edge.
- Length rules on accept:
  - L = `load_len`.
  - L > DATA_W is clamped to DATA_W.
  - L = 0: the word is accepted and discarded; no bits are sent, no `word_done` pulse, and the state is unchanged.
- Accept with L ≥ 1:
  - The shift register loads `load_data`.
  - `rem` is set to L.
  - The state becomes SHIFT.
  - The first bit appears on `ser_out` in the next cycle.
- In SHIFT, each clock advances one bit and decrements `rem`.
- When `rem`==1:
  - `word_done`=1.
  - If an accept happens at this edge, the next word's first bit follows immediately (no idle bit inserted).
  - Otherwise the block returns to IDLE.
- `load_data` and `load_len` are sampled only at the accept edge; later changes have no effect.
- Reset, including mid-word:
  - The next edge forces IDLE.
  - `rem`=0 and the shift register is cleared.
  - Outputs take IDLE values (`ser_out`=IDLE_BIT, `ser_valid`=0, `word_done`=0, `busy`=0).
  - Any in-flight word is dropped.
- A word presented while `reset` is high is not accepted.

## Timing
- Latency: accept edge k, first bit valid in the cycle after edge k; an L-bit word occupies exactly L consecutive cycles.
- `ser_out`, `ser_valid`, `word_done`, `busy` are registered (no combinational path from inputs); `load_ready` is combinational from state only.
- Sustained throughput: one bit per clock across word boundaries when upstream holds `load_valid` high.
- Detector match output then lags the final `0` of a 0110 string by one further clock (its Moore register).

## Configuration
- `SER_LSB_FIRST_EN` defined: bits are sent `load_data[0]` first, up to `load_data[L-1]`.
- Undefined (default): bits are sent `load_data[L-1]` first, down to `load_data[0]` (string order, most significant first).
- Handshake, timing and idle behaviour are identical in both builds.

## Test plan
- Reset then idle for 5 cycles -> `ser_out`=1, `ser_valid`=0, `busy`=0, `load_ready`=1 throughout.
- Default build, `load_data`=16'h0006, `load_len`=4 -> `ser_out` 0,1,1,0 on cycles 1–4 after accept; `ser_valid` high for 4 cycles; `word_done` on cycle 4; the downstream detector asserts `seq_out` on cycle 5.
- Back-to-back: word A (0x6, len 4) then B (0x5, len 3), with B valid during A's last bit -> 7 contiguous bits 0,1,1,0,1,0,1, no idle gap, two `word_done` pulses.
- `load_len`=0 -> accepted, no `ser_valid`, no `word_done`. `load_len`=40 -> clamped to 16 bits, `busy` for exactly 16 cycles.
- `reset` asserted during bit 2 of a 4-bit word -> next cycle `ser_out`=1, `ser_valid`=0, `busy`=0; no `word_done` pulse.
- `SER_LSB_FIRST_EN` defined, `load_data`=0x3, `load_len`=4 -> `ser_out` 1,1,0,0.
